// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection default, master FSM states.
// Latency: n/a. Backpressure: n/a.
// Imported by the AXI4-Lite initiator and its bench.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RSP
    } state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: single-beat cmd port -> one outstanding AXI4-Lite read or write.
// Latency: zero-wait slave, cmd accept at cycle 0 -> rsp_valid at cycle 3, cmd_ready again at cycle 4.
// Backpressure: cmd_ready only in IDLE; rsp held stable until rsp_ready; AXI VALIDs held until handshake.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR         = 32'h40000000,
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,

    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam logic [AW-1:0] BASE = AW'(C_BASEADDR);

    state_t          state, state_n;
    logic            aw_done, aw_done_n;
    logic            w_done, w_done_n;
    logic            aw_fire, w_fire;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   wstrb_q;

    // Every handshake output decodes straight from state, so an async reset clears them with no edge.
    assign cmd_ready     = (state == ST_IDLE);
    assign rsp_valid     = (state == ST_RSP);
    assign M_AXI_AWVALID = (state == ST_WR_REQ) && !aw_done;
    assign M_AXI_WVALID  = (state == ST_WR_REQ) && !w_done;
    assign M_AXI_BREADY  = (state == ST_WR_RESP);
    assign M_AXI_ARVALID = (state == ST_RD_REQ);
    assign M_AXI_RREADY  = (state == ST_RD_RESP);

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWPROT  = PROT_DEFAULT;
    assign M_AXI_ARPROT  = PROT_DEFAULT;

    assign aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_fire  = M_AXI_WVALID && M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state   <= ST_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
        end
    end

    always_comb begin
        state_n   = state;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        case (state)
            ST_IDLE: begin
                aw_done_n = 1'b0;
                w_done_n  = 1'b0;
                if (cmd_valid) state_n = cmd_write ? ST_WR_REQ : ST_RD_REQ;
            end
            ST_WR_REQ: begin
                // AW and W retire independently; leave only once both have been accepted.
                aw_done_n = aw_done || aw_fire;
                w_done_n  = w_done || w_fire;
                if (aw_done_n && w_done_n) state_n = ST_WR_RESP;
            end
            ST_WR_RESP: if (M_AXI_BVALID)  state_n = ST_RSP;
            ST_RD_REQ:  if (M_AXI_ARREADY) state_n = ST_RD_RESP;
            ST_RD_RESP: if (M_AXI_RVALID)  state_n = ST_RSP;
            ST_RSP:     if (rsp_ready)     state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
        end else begin
            if (cmd_valid && cmd_ready) begin
                addr_q  <= BASE + cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
            end
            if (state == ST_WR_RESP && M_AXI_BVALID) begin
                rsp_write <= 1'b1;
                rsp_rdata <= '0;
                rsp_resp  <= M_AXI_BRESP;
            end
            if (state == ST_RD_RESP && M_AXI_RVALID) begin
                rsp_write <= 1'b0;
                rsp_rdata <= M_AXI_RDATA;
                rsp_resp  <= M_AXI_RRESP;
            end
        end
    end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- AXI4-Lite initiator. Turns a simple single-beat command interface into AXI4-Lite read and write transactions.
- It is the initiator counterpart of the existing set/get register slave. It lets fabric logic (e.g. the accelerator controller) access AXI4-Lite register spaces.
- One transaction is outstanding at a time. The response, with read data and RESP code, is returned on a valid/ready response port.

Parameters:
- C_BASEADDR, 32'h40000000: added to cmd_addr to form the AXI address. The sum is truncated to C_M_AXI_ADDR_WIDTH.
- C_M_AXI_ADDR_WIDTH, 32: AXI address width.
- C_M_AXI_DATA_WIDTH, 32: AXI data width (32 or 64).

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  offset from C_BASEADDR
- cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data
- cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP as received
- M_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY: standard AXI4-Lite write channels; AWPROT = 3'b000
- M_AXI_ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite read channels; ARPROT = 3'b000

Behaviour:
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- Reset is asynchronous, M_AXI_ARESETN low:
  - state = IDLE
  - all VALID/READY outputs = 0, except cmd_ready, which is (state==IDLE) and therefore 1
  - AWADDR, WDATA, WSTRB, ARADDR = 0
  - rsp_write, rsp_rdata, rsp_resp = 0
- IDLE:
  - cmd_ready=1.
  - On accept, register the AXI address (C_BASEADDR+cmd_addr), wdata and wstrb.
  - Write: go to WR_REQ with AWVALID=WVALID=1 in the next cycle.
  - Read: go to RD_REQ with ARVALID=1 in the next cycle.
- WR_REQ:
  - AWVALID and WVALID drop independently on their own handshake. A handshake in the cycle VALID first rises counts.
  - AW and W may complete in either order or in the same cycle.
  - Go to WR_RESP once both have completed; BREADY=1 from the following cycle.
  - VALID is never withdrawn before its handshake. Address, data and strobe are held stable.
- WR_RESP:
  - BREADY=1.
  - On BVALID, capture BRESP into rsp_resp, set rsp_rdata=0 and rsp_write=1, go to RSP.
  - BREADY is 0 outside WR_RESP. A BVALID arriving early is simply left pending.
- RD_REQ: ARVALID held until ARREADY, then RD_RESP.
- RD_RESP: RREADY=1. On RVALID, capture RDATA and RRESP, set rsp_write=0, go to RSP.
- RSP:
  - rsp_valid=1; payload is stable until rsp_ready.
  - On handshake, go to IDLE.
  - cmd_ready is 0, so no command overlaps a pending response.
- Latency, zero-wait slave, rsp_ready tied 1, with cmd accepted at cycle 0:
  - Write: AW/W handshake cycle 1, B handshake cycle 2, rsp_valid cycle 3, cmd_ready again cycle 4.
  - Read: same timing.
- RESP codes SLVERR and DECERR are passed through unchanged. No retry is performed.
- Reset mid-transaction: everything returns to reset values immediately. The transaction is abandoned, matching the interconnect reset.
- Address arithmetic wraps modulo 2^C_M_AXI_ADDR_WIDTH.

Decomposition:
- Shared package axi4_lite_pkg:
  - RESP constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - state encodings
  - PROT default 3'b000
- No sub-module; a single FSM with per-channel done flags.

Test Plan:
- Write, zero-wait slave: cmd_addr=0x10, wdata=0xDEADBEEF, wstrb=0xF. Required: AWADDR=0x40000010, WDATA=0xDEADBEEF, rsp_valid at cycle 3 with rsp_write=1, rsp_resp=0.
- Read, slave returns 0x12345678 after 5 wait cycles on RVALID. Required: RREADY held throughout, rsp_rdata=0x12345678, rsp_resp=0, rsp_write=0.
- Skewed write handshake:
  - AWREADY delayed 3 cycles, WREADY immediate: WVALID drops after 1 cycle, AWVALID holds, BREADY rises only after both handshakes complete.
  - Reverse order (WREADY delayed, AWREADY immediate): same result.
- Error and backpressure: slave returns RRESP=2'b10 and rsp_ready is held 0 for 4 cycles. Required: rsp_valid and the payload stay stable, cmd_ready=0, and a new cmd_valid is not accepted until after the rsp handshake.
- Reset mid-write: assert M_AXI_ARESETN low while in WR_REQ. Required: AWVALID, WVALID and rsp_valid go to 0 without a clock edge. After release, cmd_ready=1 and the next read completes normally.
- Address wrap: cmd_addr=0xC0000004. Required: ARADDR=0x00000004.
